// File: rtl/coreriscv_axi4_tl_pkg.sv
// Purpose: shared field widths, bundle widths and pack offsets for the uncached TileLink queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package coreriscv_axi4_tl_pkg;

  // Field widths
  localparam int ADDR_BLOCK_W = 26;
  localparam int ADDR_BEAT_W  = 3;
  localparam int A_TYPE_W     = 3;
  localparam int UNION_W      = 12;
  localparam int G_TYPE_W     = 4;
  localparam int MGR_XID_W    = 2;
  localparam int CLI_XID_W    = 1;
  localparam int DATA_W       = 64;

  // Acquire field LSB offsets (packed MSB->LSB in struct order)
  localparam int ACQ_DATA_LSB    = 0;
  localparam int ACQ_UNION_LSB   = ACQ_DATA_LSB + DATA_W;          // 64
  localparam int ACQ_ATYPE_LSB   = ACQ_UNION_LSB + UNION_W;        // 76
  localparam int ACQ_BUILTIN_LSB = ACQ_ATYPE_LSB + A_TYPE_W;       // 79
  localparam int ACQ_BEAT_LSB    = ACQ_BUILTIN_LSB + 1;            // 80
  localparam int ACQ_XID_LSB     = ACQ_BEAT_LSB + ADDR_BEAT_W;     // 83
  localparam int ACQ_BLOCK_LSB   = ACQ_XID_LSB + CLI_XID_W;        // 84
  localparam int ACQ_W           = ACQ_BLOCK_LSB + ADDR_BLOCK_W;   // 110

  // Grant field LSB offsets
  localparam int GNT_DATA_LSB    = 0;
  localparam int GNT_GTYPE_LSB   = GNT_DATA_LSB + DATA_W;          // 64
  localparam int GNT_BUILTIN_LSB = GNT_GTYPE_LSB + G_TYPE_W;       // 68
  localparam int GNT_MXID_LSB    = GNT_BUILTIN_LSB + 1;            // 69
  localparam int GNT_XID_LSB     = GNT_MXID_LSB + MGR_XID_W;       // 71
  localparam int GNT_BEAT_LSB    = GNT_XID_LSB + CLI_XID_W;        // 72
  localparam int GNT_W           = GNT_BEAT_LSB + ADDR_BEAT_W;     // 75

  typedef struct packed {
    logic [ADDR_BLOCK_W-1:0] addr_block;
    logic [CLI_XID_W-1:0]    client_xact_id;
    logic [ADDR_BEAT_W-1:0]  addr_beat;
    logic                    is_builtin_type;
    logic [A_TYPE_W-1:0]     a_type;
    logic [UNION_W-1:0]      union_bits;
    logic [DATA_W-1:0]       data;
  } acq_t;

  typedef struct packed {
    logic [ADDR_BEAT_W-1:0]  addr_beat;
    logic [CLI_XID_W-1:0]    client_xact_id;
    logic [MGR_XID_W-1:0]    manager_xact_id;
    logic                    is_builtin_type;
    logic [G_TYPE_W-1:0]     g_type;
    logic [DATA_W-1:0]       data;
  } gnt_t;

endpackage

// File: rtl/coreriscv_axi4_tl_fifo.sv
// Purpose: generic registered FIFO; all outputs come from registers, no bypass.
// Latency: 1 cycle from accepted enqueue to out_vld_o on an empty queue.
// Backpressure: in_rdy_o low when full (even if a dequeue happens that cycle); sender holds.
// Ports: clk_i, rst_ni (async active-low), in_vld_i/in_rdy_o/in_dat_i, out_vld_o/out_rdy_i/out_dat_o.
module coreriscv_axi4_tl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  input  logic [WIDTH-1:0] in_dat_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [WIDTH-1:0] out_dat_o
);

  // A single-entry FIFO still needs a 1-bit pointer so the array index is legal.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq, deq;

  // Ready/valid derive from count only so no same-cycle input reaches an output.
  assign in_rdy_o  = (count_q != CNT_FULL);
  assign out_vld_o = (count_q != '0);
  assign out_dat_o = mem_q[head_q];

  assign enq = in_vld_i & in_rdy_o;
  assign deq = out_vld_o & out_rdy_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // Explicit wrap compare keeps non-power-of-two depths correct.
    if (enq) begin
      tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + PTR_W'(1);
    end
    if (deq) begin
      head_d = (head_q == PTR_LAST) ? '0 : head_q + PTR_W'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so the head output reads 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (enq) begin
      mem_q[tail_q] <= in_dat_i;
    end
  end

endmodule

// File: rtl/coreriscv_axi4_tile_link_io_queue.sv
// Purpose: registered acquire (in->out) and grant (out->in) buffers between TL arbiter and AXI4 converter.
// Latency: 1 cycle enqueue-to-valid per direction; 1 entry/cycle for depth >= 2.
// Backpressure: each *_ready is "FIFO not full" from registers only; senders hold valid.
// Ports: clk, reset (async active-low), io_in_acquire_* (core side in), io_out_acquire_* (bus side out),
//        io_out_grant_* (bus side in), io_in_grant_* (core side out).
module coreriscv_axi4_tile_link_io_queue
  import coreriscv_axi4_tl_pkg::*;
#(
  parameter int ACQ_DEPTH = 2,
  parameter int GNT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_acquire_valid,
  output logic             io_in_acquire_ready,
  input  logic [ACQ_W-1:0] io_in_acquire_bits,
  output logic             io_out_acquire_valid,
  input  logic             io_out_acquire_ready,
  output logic [ACQ_W-1:0] io_out_acquire_bits,
  input  logic             io_out_grant_valid,
  output logic             io_out_grant_ready,
  input  logic [GNT_W-1:0] io_out_grant_bits,
  output logic             io_in_grant_valid,
  input  logic             io_in_grant_ready,
  output logic [GNT_W-1:0] io_in_grant_bits
);

  coreriscv_axi4_tl_fifo #(
    .WIDTH (ACQ_W),
    .DEPTH (ACQ_DEPTH)
  ) u_acq_fifo (
    .clk_i     (clk),
    .rst_ni    (reset),
    .in_vld_i  (io_in_acquire_valid),
    .in_rdy_o  (io_in_acquire_ready),
    .in_dat_i  (io_in_acquire_bits),
    .out_vld_o (io_out_acquire_valid),
    .out_rdy_i (io_out_acquire_ready),
    .out_dat_o (io_out_acquire_bits)
  );

  coreriscv_axi4_tl_fifo #(
    .WIDTH (GNT_W),
    .DEPTH (GNT_DEPTH)
  ) u_gnt_fifo (
    .clk_i     (clk),
    .rst_ni    (reset),
    .in_vld_i  (io_out_grant_valid),
    .in_rdy_o  (io_out_grant_ready),
    .in_dat_i  (io_out_grant_bits),
    .out_vld_o (io_in_grant_valid),
    .out_rdy_i (io_in_grant_ready),
    .out_dat_o (io_in_grant_bits)
  );

endmodule

// File: tb/tb_coreriscv_axi4_tile_link_io_queue.sv
module tb_coreriscv_axi4_tile_link_io_queue;
  import coreriscv_axi4_tl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Directed instance: default depths 2/2
  logic             a_in_acq_vld, a_in_acq_rdy, a_out_acq_vld, a_out_acq_rdy;
  logic [ACQ_W-1:0] a_in_acq_bits, a_out_acq_bits;
  logic             a_out_gnt_vld, a_out_gnt_rdy, a_in_gnt_vld, a_in_gnt_rdy;
  logic [GNT_W-1:0] a_out_gnt_bits, a_in_gnt_bits;

  // Random instance: ACQ_DEPTH=3, GNT_DEPTH=1
  logic             r_in_acq_vld, r_in_acq_rdy, r_out_acq_vld, r_out_acq_rdy;
  logic [ACQ_W-1:0] r_in_acq_bits, r_out_acq_bits;
  logic             r_out_gnt_vld, r_out_gnt_rdy, r_in_gnt_vld, r_in_gnt_rdy;
  logic [GNT_W-1:0] r_out_gnt_bits, r_in_gnt_bits;

  coreriscv_axi4_tile_link_io_queue #(.ACQ_DEPTH(2), .GNT_DEPTH(2)) u_dut (
    .clk                  (clk),
    .reset                (reset),
    .io_in_acquire_valid  (a_in_acq_vld),
    .io_in_acquire_ready  (a_in_acq_rdy),
    .io_in_acquire_bits   (a_in_acq_bits),
    .io_out_acquire_valid (a_out_acq_vld),
    .io_out_acquire_ready (a_out_acq_rdy),
    .io_out_acquire_bits  (a_out_acq_bits),
    .io_out_grant_valid   (a_out_gnt_vld),
    .io_out_grant_ready   (a_out_gnt_rdy),
    .io_out_grant_bits    (a_out_gnt_bits),
    .io_in_grant_valid    (a_in_gnt_vld),
    .io_in_grant_ready    (a_in_gnt_rdy),
    .io_in_grant_bits     (a_in_gnt_bits)
  );

  coreriscv_axi4_tile_link_io_queue #(.ACQ_DEPTH(3), .GNT_DEPTH(1)) u_dut_rnd (
    .clk                  (clk),
    .reset                (reset),
    .io_in_acquire_valid  (r_in_acq_vld),
    .io_in_acquire_ready  (r_in_acq_rdy),
    .io_in_acquire_bits   (r_in_acq_bits),
    .io_out_acquire_valid (r_out_acq_vld),
    .io_out_acquire_ready (r_out_acq_rdy),
    .io_out_acquire_bits  (r_out_acq_bits),
    .io_out_grant_valid   (r_out_gnt_vld),
    .io_out_grant_ready   (r_out_gnt_rdy),
    .io_out_grant_bits    (r_out_gnt_bits),
    .io_in_grant_valid    (r_in_gnt_vld),
    .io_in_grant_ready    (r_in_gnt_rdy),
    .io_in_grant_bits     (r_in_gnt_bits)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  acq_t             acq;
  gnt_t             gnt;
  logic [127:0]     tmp;
  logic [ACQ_W-1:0] e1, e2, e3, prev;
  logic [ACQ_W-1:0] q_acq [$];
  logic [GNT_W-1:0] q_gnt [$];
  localparam int N_TXN  = 10000;
  localparam int BUDGET = 60000;

  initial begin
    a_in_acq_vld = 0; a_in_acq_bits = '0; a_out_acq_rdy = 0;
    a_out_gnt_vld = 0; a_out_gnt_bits = '0; a_in_gnt_rdy = 0;
    r_in_acq_vld = 0; r_in_acq_bits = '0; r_out_acq_rdy = 0;
    r_out_gnt_vld = 0; r_out_gnt_bits = '0; r_in_gnt_rdy = 0;

    // ---- reset and idle ----
    repeat (3) tick();
    chk("rst_acq_in_rdy",  a_in_acq_rdy, 1'b1);
    chk("rst_gnt_out_rdy", a_out_gnt_rdy, 1'b1);
    chk("rst_acq_out_vld", a_out_acq_vld, 1'b0);
    chk("rst_gnt_in_vld",  a_in_gnt_vld, 1'b0);
    chk("rst_acq_bits",    a_out_acq_bits, '0);
    chk("rst_gnt_bits",    a_in_gnt_bits, '0);
    reset = 1'b1;
    tick();
    chk("idle_acq_out_vld", a_out_acq_vld, 1'b0);
    chk("idle_gnt_in_vld",  a_in_gnt_vld, 1'b0);
    chk("idle_acq_in_rdy",  a_in_acq_rdy, 1'b1);

    // ---- single acquire ----
    acq = '0;
    acq.addr_block = 26'h0000123;
    acq.a_type     = 3'b011;
    acq.data       = 64'hDEADBEEF_00000001;
    a_in_acq_bits = acq;
    a_in_acq_vld  = 1'b1;
    #1;
    chk("single_no_bypass", a_out_acq_vld, 1'b0);
    tick();
    a_in_acq_vld = 1'b0;
    chk("single_vld_n1", a_out_acq_vld, 1'b1);
    chk("single_bits",   a_out_acq_bits, acq);
    a_out_acq_rdy = 1'b1;
    tick();
    chk("single_cleared", a_out_acq_vld, 1'b0);
    a_out_acq_rdy = 1'b0;

    // ---- 8-beat grant burst, arbiter always ready ----
    a_in_gnt_rdy  = 1'b1;
    a_out_gnt_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      gnt = '0;
      gnt.addr_beat = 3'(i);
      gnt.g_type    = 4'h5;
      gnt.data      = 64'hA5A5_0000_0000_0000 | 64'(i);
      a_out_gnt_bits = gnt;
      tick();
      chk("burst_vld",  a_in_gnt_vld, 1'b1);
      chk("burst_beat", a_in_gnt_bits, gnt);
      chk("burst_rdy",  a_out_gnt_rdy, 1'b1);
    end
    a_out_gnt_vld = 1'b0;
    tick();
    chk("burst_drained", a_in_gnt_vld, 1'b0);

    // ---- backpressure: 3 acquires into depth 2 ----
    e1 = {26'h1, 1'b0, 3'd0, 1'b1, 3'd1, 12'h111, 64'h1111};
    e2 = {26'h2, 1'b1, 3'd1, 1'b0, 3'd2, 12'h222, 64'h2222};
    e3 = {26'h3, 1'b0, 3'd2, 1'b1, 3'd3, 12'h333, 64'h3333};
    a_in_acq_vld = 1'b1;
    a_in_acq_bits = e1;
    tick();
    chk("bp_rdy_after1", a_in_acq_rdy, 1'b1);
    a_in_acq_bits = e2;
    tick();
    chk("bp_rdy_after2", a_in_acq_rdy, 1'b0);
    a_in_acq_bits = e3;
    tick();
    chk("bp_rdy_held", a_in_acq_rdy, 1'b0);
    chk("bp_head_e1",  a_out_acq_bits, e1);
    // Full with deq and enq both requested: only deq happens.
    a_out_acq_rdy = 1'b1;
    tick();
    chk("full_deq_only_rdy", a_in_acq_rdy, 1'b1);
    chk("full_deq_head_e2",  a_out_acq_bits, e2);
    tick();
    a_in_acq_vld = 1'b0;
    chk("bp_head_e3", a_out_acq_bits, e3);
    chk("bp_vld_e3",  a_out_acq_vld, 1'b1);
    tick();
    chk("bp_drained", a_out_acq_vld, 1'b0);

    // ---- half full with simultaneous enq+deq for 100 cycles ----
    a_out_acq_rdy = 1'b0;
    a_in_acq_vld = 1'b1;
    tmp = rnd128(); a_in_acq_bits = tmp[ACQ_W-1:0];
    tick();
    a_out_acq_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tmp = rnd128(); prev = tmp[ACQ_W-1:0];
      a_in_acq_bits = prev;
      tick();
      chk("half_vld",  a_out_acq_vld, 1'b1);
      chk("half_rdy",  a_in_acq_rdy, 1'b1);
      chk("half_head", a_out_acq_bits, prev);
    end
    a_in_acq_vld = 1'b0;
    tick();
    chk("half_drained", a_out_acq_vld, 1'b0);

    // ---- reset mid-operation with 2 entries held ----
    a_out_acq_rdy = 1'b0;
    a_in_acq_vld = 1'b1;
    a_in_acq_bits = e1; tick();
    a_in_acq_bits = e2; tick();
    a_in_acq_vld = 1'b0;
    chk("pre_rst_full", a_in_acq_rdy, 1'b0);
    reset = 1'b0;
    tick();
    chk("mid_rst_acq_vld", a_out_acq_vld, 1'b0);
    chk("mid_rst_acq_rdy", a_in_acq_rdy, 1'b1);
    chk("mid_rst_bits",    a_out_acq_bits, '0);
    chk("mid_rst_gnt_rdy", a_out_gnt_rdy, 1'b1);
    reset = 1'b1;
    tick();
    chk("post_rst_vld", a_out_acq_vld, 1'b0);

    // ---- random traffic on depth 3 / depth 1 instance ----
    begin
      int n_acq = 0, n_gnt = 0, s_acq = 0, s_gnt = 0, cyc = 0;
      logic hs_ai, hs_ao, hs_gi, hs_go;
      while ((n_acq < N_TXN || n_gnt < N_TXN) && cyc < BUDGET) begin
        chk("rnd_acq_vld", r_out_acq_vld, (q_acq.size() != 0));
        chk("rnd_acq_rdy", r_in_acq_rdy,  (q_acq.size() != 3));
        chk("rnd_gnt_vld", r_in_gnt_vld,  (q_gnt.size() != 0));
        chk("rnd_gnt_rdy", r_out_gnt_rdy, (q_gnt.size() != 1));
        hs_ai = r_in_acq_vld & r_in_acq_rdy;
        hs_ao = r_out_acq_vld & r_out_acq_rdy;
        hs_gi = r_out_gnt_vld & r_out_gnt_rdy;
        hs_go = r_in_gnt_vld & r_in_gnt_rdy;
        if (hs_ao) chk("rnd_acq_data", r_out_acq_bits, q_acq[0]);
        if (hs_go) chk("rnd_gnt_data", r_in_gnt_bits, q_gnt[0]);
        tick();
        cyc++;
        if (hs_ao) begin void'(q_acq.pop_front()); n_acq++; end
        if (hs_go) begin void'(q_gnt.pop_front()); n_gnt++; end
        if (hs_ai) begin q_acq.push_back(r_in_acq_bits); s_acq++; end
        if (hs_gi) begin q_gnt.push_back(r_out_gnt_bits); s_gnt++; end
        // A sender only changes its beat once the previous one was taken.
        if (!r_in_acq_vld || hs_ai) begin
          r_in_acq_vld = ($urandom_range(7) != 0) && (s_acq < N_TXN);
          tmp = rnd128(); r_in_acq_bits = tmp[ACQ_W-1:0];
        end
        if (!r_out_gnt_vld || hs_gi) begin
          r_out_gnt_vld = ($urandom_range(7) != 0) && (s_gnt < N_TXN);
          tmp = rnd128(); r_out_gnt_bits = tmp[GNT_W-1:0];
        end
        r_out_acq_rdy = ($urandom_range(7) != 0);
        r_in_gnt_rdy  = ($urandom_range(7) != 0);
      end
      chk("rnd_all_done", (n_acq >= N_TXN) && (n_gnt >= N_TXN), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coreriscv_axi4_tile_link_io_queue.md
# coreriscv_axi4_tile_link_io_queue

Registered two-channel buffer for the uncached TileLink port, sitting directly downstream of the client uncached TileLink arbiter and upstream of the TileLink-to-AXI4 converter. It decouples the arbiter's combinational acquire/grant path from the converter with an independent FIFO per direction. It also breaks every valid/ready timing path between the core side and the bus side.

## Interface
Parameters:
- ACQ_DEPTH, 2, acquire FIFO entries (≥1)
- GNT_DEPTH, 2, grant FIFO entries (≥1)

Ports (bundles packed MSB→LSB in package field order):
- clk  in  1  single clock, all state rising-edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- io_in_acquire_valid  in  1  acquire from arbiter io_out
- io_in_acquire_ready  out  1  acquire FIFO not full
- io_in_acquire_bits  in  110  {addr_block[25:0], client_xact_id, addr_beat[2:0], is_builtin_type, a_type[2:0], union[11:0], data[63:0]}
- io_out_acquire_valid  out  1  acquire FIFO not empty
- io_out_acquire_ready  in  1  converter accepts acquire
- io_out_acquire_bits  out  110  head acquire entry
- io_out_grant_valid  in  1  grant from converter
- io_out_grant_ready  out  1  grant FIFO not full
- io_out_grant_bits  in  75  {addr_beat[2:0], client_xact_id, manager_xact_id[1:0], is_builtin_type, g_type[3:0], data[63:0]}
- io_in_grant_valid  out  1  grant FIFO not empty, to arbiter
- io_in_grant_ready  in  1  arbiter accepts grant
- io_in_grant_bits  out  75  head grant entry

## Operation
- Two identical, independent FIFOs: acquire (in→out), grant (out→in). No field is interpreted or modified; multi-beat bursts pass as consecutive entries, order preserved.
- Per FIFO: head pointer, tail pointer, count (width clog2(DEPTH+1)).
- Enqueue when in_valid & in_ready: write mem[tail], tail advances. Dequeue when out_valid & out_ready: head advances.
- Pointers wrap from DEPTH-1 to 0 (non-power-of-two depths supported, explicit compare, no modulo).
- count: +1 on enq only, -1 on deq only, unchanged on both or neither.
- in_ready = (count != DEPTH); out_valid = (count != 0); out_bits = mem[head]. All are functions of registers only, never of same-cycle inputs.
- Full: in_ready=0 even if a dequeue occurs in the same cycle (no same-cycle slot reuse). Empty: no bypass; out_valid stays 0 in the cycle of the first enqueue.
- Simultaneous enq+deq with 0<count<DEPTH: both occur, count constant.
- Valid asserted while ready=0 is held by the sender; the queue does not drop or duplicate.
- Reset (any time, including mid-burst): pointers and count to 0, all storage entries to 0. In-flight entries are discarded. No partial-burst recovery.

## Timing
- Reset values: io_in_acquire_ready=1, io_out_grant_ready=1, io_out_acquire_valid=0, io_in_grant_valid=0, both *_bits outputs = 0.
- Latency: 1 cycle from accepted enqueue to out_valid (empty queue).
- Throughput: 1 entry/cycle sustained for DEPTH≥2. DEPTH=1 gives 1 entry per 2 cycles.
- Reset deassertion is synchronised by the system reset controller. Block's first active edge is the one after deassertion.

## Structure
- Package coreriscv_axi4_tl_pkg holds: field widths (addr_block 26, addr_beat 3, a_type 3, union 12, g_type 4, manager_xact_id 2, data 64), ACQ_W=110, GNT_W=75, field LSB offsets for pack/unpack.
- One sub-module, coreriscv_axi4_tl_fifo (params WIDTH, DEPTH), instantiated twice. The top level is wiring only.

## Test plan
- Reset then idle -> both readys 1, both valids 0, bits 0. Reset asserted mid-operation with 2 entries held -> next cycle valids 0, readys 1.
- Single acquire addr_block=0x0000123, a_type=3'b011, data=0xDEADBEEF_00000001 at cycle N -> io_out_acquire_valid at N+1, bits identical, cleared after out_ready handshake.
- 8-beat grant burst (addr_beat 0..7), io_in_grant_ready held 1 -> all 8 beats delivered in order on 8 consecutive cycles after a 1-cycle fill.
- Out_ready=0, push 3 acquires with ACQ_DEPTH=2 -> ready drops after 2nd; 3rd held; enabling out_ready releases entries 1,2,3 in order, none lost.
- Full queue with deq and enq valid in the same cycle -> deq only, ready rises next cycle. Half-full with simultaneous enq+deq -> count stays 1 for 100 random cycles.
- ACQ_DEPTH=3, GNT_DEPTH=1, random valid/ready for 10k transactions -> scoreboard order/data match, pointer wrap exercised, no X on outputs.
